// File: rtl/dcache_pkg.sv
// Shared widths, tag-entry layout, controller states and address field helpers
// for the 2-way set-associative L1 data cache controller.
package dcache_pkg;

    localparam int ADDR_W  = 32;
    localparam int TAG_W   = 23;
    localparam int IDX_W   = 4;
    localparam int OFS_W   = 5;
    localparam int WORD_W  = 32;
    localparam int LINE_W  = 256;

    // Tag entry is {valid, dirty, tag}
    localparam int ENTRY_W   = TAG_W + 2;
    localparam int VALID_BIT = 24;
    localparam int DIRTY_BIT = 23;

    // Word select inside a line: byte offset minus the two in-word bits
    localparam int WSEL_W = OFS_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        FILL,
        REFILL
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return addr[OFS_W +: IDX_W];
    endfunction

    function automatic logic [WSEL_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
        return addr[2 +: WSEL_W];
    endfunction

    // Line-aligned memory address: offset bits forced to zero
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [IDX_W-1:0] idx);
        return {tag, idx, {OFS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_word_mux.sv
// Read-word select and write-word merge on one 256-bit cache line.
module dcache_word_mux
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line,
    input  logic [WSEL_W-1:0] word_sel,
    input  logic [WORD_W-1:0] wr_word,
    output logic [WORD_W-1:0] rd_word,
    output logic [LINE_W-1:0] merged
);

    // Pick the addressed word and build the line with that word replaced
    always_comb begin
        // NOTE: combinational logic uses blocking assignments, and every output
        // gets a full default first so no latch can be inferred.
        rd_word = line[word_sel*WORD_W +: WORD_W];
        merged  = line;
        merged[word_sel*WORD_W +: WORD_W] = wr_word;
    end

endmodule

// File: rtl/dcache_controller.sv
// L1 dcache sequencing controller: zero-latency hits, and on a miss an optional
// dirty-victim write-back, a line fill, an SRAM refill and a replay in IDLE.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cpu_req_i,
    input  logic                cpu_write_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [WORD_W-1:0]   cpu_data_i,
    output logic [WORD_W-1:0]   cpu_data_o,
    output logic                cpu_stall_o,
    output logic [IDX_W-1:0]    sram_addr_o,
    output logic [ENTRY_W-1:0]  sram_tag_o,
    output logic [LINE_W-1:0]   sram_data_o,
    output logic                sram_enable_o,
    output logic                sram_write_o,
    input  logic [ENTRY_W-1:0]  sram_tag_i,
    input  logic [LINE_W-1:0]   sram_data_i,
    input  logic                sram_hit_i,
    output logic                mem_enable_o,
    output logic                mem_write_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [LINE_W-1:0]   mem_data_o,
    input  logic [LINE_W-1:0]   mem_data_i,
    input  logic                mem_ack_i
);

    state_t               state;
    logic [ENTRY_W-1:0]   victim_tag;
    logic [LINE_W-1:0]    victim_data;
    logic [LINE_W-1:0]    fill_buf;
    logic [ADDR_W-1:0]    miss_addr;

    logic [WSEL_W-1:0]    word_sel;
    logic [WORD_W-1:0]    rd_word;
    logic [LINE_W-1:0]    merged_line;
    logic                 victim_dirty;

    assign word_sel     = addr_word(cpu_addr_i);
    assign victim_dirty = victim_tag[VALID_BIT] && victim_tag[DIRTY_BIT];

    dcache_word_mux u_word_mux (
        .line     (sram_data_i),
        .word_sel (word_sel),
        .wr_word  (cpu_data_i),
        .rd_word  (rd_word),
        .merged   (merged_line)
    );

    // Miss sequencer: latch victim and request address, then walk the miss states
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values; the line buffers are ordinary flops (not an
        // SRAM macro), so clearing them on reset is legitimate.
        if (rst_i) begin
            state       <= IDLE;
            victim_tag  <= '0;
            victim_data <= '0;
            fill_buf    <= '0;
            miss_addr   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_req_i && !sram_hit_i) begin
                        victim_tag  <= sram_tag_i;
                        victim_data <= sram_data_i;
                        miss_addr   <= cpu_addr_i;
                        state       <= MISS;
                    end
                end
                MISS:      state <= victim_dirty ? WRITEBACK : FILL;
                WRITEBACK: if (mem_ack_i) state <= FILL;
                FILL: begin
                    if (mem_ack_i) begin
                        fill_buf <= mem_data_i;
                        state    <= REFILL;
                    end
                end
                REFILL:    state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // Output decode: hit path is combinational in IDLE; reset forces every output low
    always_comb begin
        cpu_data_o    = '0;
        cpu_stall_o   = 1'b0;
        sram_addr_o   = '0;
        sram_tag_o    = '0;
        sram_data_o   = '0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        if (!rst_i) begin
            unique case (state)
                IDLE: begin
                    sram_addr_o = addr_idx(cpu_addr_i);
                    if (cpu_req_i) begin
                        sram_enable_o = 1'b1;
                        if (!sram_hit_i) begin
                            cpu_stall_o = 1'b1;
                        end else if (cpu_write_i) begin
                            sram_write_o = 1'b1;
                            sram_tag_o   = {1'b1, 1'b1, addr_tag(cpu_addr_i)};
                            sram_data_o  = merged_line;
                        end else begin
                            cpu_data_o = rd_word;
                        end
                    end
                end
                MISS: begin
                    cpu_stall_o = 1'b1;
                    sram_addr_o = addr_idx(miss_addr);
                end
                WRITEBACK: begin
                    cpu_stall_o  = 1'b1;
                    sram_addr_o  = addr_idx(miss_addr);
                    mem_enable_o = 1'b1;
                    mem_write_o  = 1'b1;
                    mem_addr_o   = line_addr(victim_tag[TAG_W-1:0], addr_idx(miss_addr));
                    mem_data_o   = victim_data;
                end
                FILL: begin
                    cpu_stall_o  = 1'b1;
                    sram_addr_o  = addr_idx(miss_addr);
                    mem_enable_o = 1'b1;
                    mem_addr_o   = line_addr(addr_tag(miss_addr), addr_idx(miss_addr));
                end
                REFILL: begin
                    cpu_stall_o   = 1'b1;
                    sram_addr_o   = addr_idx(miss_addr);
                    sram_enable_o = 1'b1;
                    sram_write_o  = 1'b1;
                    sram_tag_o    = {1'b1, 1'b0, addr_tag(miss_addr)};
                    sram_data_o   = fill_buf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: behavioural 2-way SRAM and memory
// models around the DUT; expected loads and memory transactions are queued by
// the stimulus and popped by independent monitors.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_write_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o, sram_tag_i;
    logic [255:0] sram_data_o, sram_data_i;
    logic         sram_enable_o, sram_write_o, sram_hit_i;
    logic         mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    dcache_controller dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line pattern: word k = base + k
    function automatic logic [255:0] pat(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
        return l;
    endfunction

    // ---------------- SRAM model (2 ways, LRU per set) ----------------
    logic [24:0]  m_tag  [16][2];
    logic [255:0] m_data [16][2];
    logic         m_lru  [16];
    logic         mdl_init;
    logic         h0, h1, wsel;

    always_comb begin
        h0 = m_tag[sram_addr_o][0][24] && (m_tag[sram_addr_o][0][22:0] == cpu_addr_i[31:9]);
        h1 = m_tag[sram_addr_o][1][24] && (m_tag[sram_addr_o][1][22:0] == cpu_addr_i[31:9]);
        sram_hit_i = sram_enable_o && (h0 || h1);
        wsel = h0 ? 1'b0 : (h1 ? 1'b1 : m_lru[sram_addr_o]);
        sram_tag_i  = m_tag[sram_addr_o][wsel];
        sram_data_i = m_data[sram_addr_o][wsel];
    end

    initial forever begin
        @(posedge clk_i);
        if (mdl_init) begin
            for (int s = 0; s < 16; s++) begin
                m_lru[s] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    if (s == 3 && w == 0) begin
                        m_tag[s][w]  <= {2'b10, 23'h00ABC};
                        m_data[s][w] <= pat(32'hA000_0000);
                    end else if (s == 2 && w == 1) begin
                        m_tag[s][w]  <= {2'b11, 23'h000055};
                        m_data[s][w] <= pat(32'h5500_0000);
                    end else if (s == 5 && w == 0) begin
                        m_tag[s][w]  <= {2'b11, 23'h000033};
                        m_data[s][w] <= pat(32'h3300_0000);
                    end else if (s == 7 && w == 0) begin
                        m_tag[s][w]  <= {2'b01, 23'h000011};
                        m_data[s][w] <= pat(32'h1100_0000);
                    end else begin
                        m_tag[s][w]  <= '0;
                        m_data[s][w] <= '0;
                    end
                end
            end
        end else if (sram_enable_o && sram_write_o) begin
            m_tag[sram_addr_o][wsel]  <= sram_tag_o;
            m_data[sram_addr_o][wsel] <= sram_data_o;
            m_lru[sram_addr_o]        <= ~wsel;
        end else if (sram_hit_i) begin
            m_lru[sram_addr_o] <= ~wsel;
        end
    end

    // ---------------- memory model ----------------
    int   mem_lat = 10;
    int   mem_cnt = 0;
    logic resp_ack = 1'b0;
    logic manual_ack = 1'b0;
    assign mem_ack_i  = resp_ack | manual_ack;
    assign mem_data_i = pat({mem_addr_o[15:0], 16'h0000});

    initial forever begin
        @(negedge clk_i);
        if (!mem_enable_o) begin
            resp_ack = 1'b0;
            mem_cnt  = 0;
        end else if (mem_cnt + 1 >= mem_lat) begin
            resp_ack = 1'b1;
            mem_cnt  = 0;
        end else begin
            resp_ack = 1'b0;
            mem_cnt++;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    logic [31:0] exp_load[$];
    txn_t        exp_txn[$];

    // Load monitor: a completed load is a request with no stall
    initial forever begin
        @(negedge clk_i);
        if (!rst_i && cpu_req_i && !cpu_write_i && !cpu_stall_o) begin
            if (exp_load.size() == 0) check("load_unexpected", cpu_data_o, '1);
            else check("load_data", cpu_data_o, exp_load.pop_front());
        end
    end

    // Memory monitor: a new transaction starts on enable rise or any change of its fields
    logic        prev_en = 1'b0, prev_wr = 1'b0;
    logic [31:0] prev_addr = '0;
    initial forever begin
        @(negedge clk_i);
        if (mem_enable_o && (!prev_en || prev_wr != mem_write_o || prev_addr != mem_addr_o)) begin
            if (exp_txn.size() == 0) begin
                check("txn_unexpected", {mem_write_o, mem_addr_o}, '1);
            end else begin
                txn_t t;
                t = exp_txn.pop_front();
                check("txn_write", mem_write_o, t.wr);
                check("txn_addr", mem_addr_o, t.addr);
                if (t.wr) check("txn_data", mem_data_o, t.data);
            end
        end
        prev_en   = mem_enable_o;
        prev_wr   = mem_write_o;
        prev_addr = mem_addr_o;
    end

    // ---------------- stimulus ----------------
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_stall, input string name);
        int stalls = 0;
        @(posedge clk_i); #1;
        cpu_req_i   = 1'b1;
        cpu_write_i = wr;
        cpu_addr_i  = addr;
        cpu_data_i  = wdata;
        @(negedge clk_i);
        while (cpu_stall_o && stalls < 300) begin
            stalls++;
            @(negedge clk_i);
        end
        check({name, "_stall"}, stalls, exp_stall);
        check({name, "_memen"}, mem_enable_o, 1'b0);
        check({name, "_swrite"}, sram_write_o, wr);
    endtask

    task automatic idle();
        @(posedge clk_i); #1;
        cpu_req_i   = 1'b0;
        cpu_write_i = 1'b0;
    endtask

    initial begin
        int n;
        rst_i = 1'b1; mdl_init = 1'b1;
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h0015_7868; cpu_data_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_outputs", {cpu_stall_o, sram_enable_o, sram_write_o, mem_enable_o,
               mem_write_o, cpu_data_o, mem_addr_o, sram_tag_o, sram_addr_o}, '0);
        mdl_init = 1'b0; cpu_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;

        // 1/2: back-to-back hits in set 3: load, store, load
        exp_load.push_back(32'hA000_0002);
        access(1'b0, 32'h0015_7868, '0, 0, "hit_load");
        access(1'b1, 32'h0015_7868, 32'hDEAD_BEEF, 0, "hit_store");
        check("hit_store_tag", sram_tag_o, {2'b11, 23'h00ABC});
        exp_load.push_back(32'hDEAD_BEEF);
        access(1'b0, 32'h0015_7868, '0, 0, "hit_reload");

        // 3: clean miss, fill latency 10 -> 13 stall cycles
        mem_lat = 10;
        exp_txn.push_back('{wr: 1'b0, addr: 32'h0000_1240, data: '0});
        exp_load.push_back(32'h1240_0002);
        access(1'b0, 32'h0000_1248, '0, 13, "clean_miss");

        // invalid but dirty victim in set 7 must not be written back
        mem_lat = 2;
        exp_txn.push_back('{wr: 1'b0, addr: 32'h0000_44E0, data: '0});
        exp_load.push_back(32'h44E0_0003);
        access(1'b0, 32'h0000_44EC, '0, 5, "invalid_victim");

        // 4: store miss with dirty victim {1,1,0x55} in set 2
        mem_lat = 4;
        exp_txn.push_back('{wr: 1'b1, addr: 32'h0000_AA40, data: pat(32'h5500_0000)});
        exp_txn.push_back('{wr: 1'b0, addr: 32'h0000_EE40, data: '0});
        access(1'b1, 32'h0000_EE44, 32'hCAFE_F00D, 11, "dirty_miss");
        check("dirty_miss_tag", sram_tag_o, {2'b11, 23'h000077});
        exp_load.push_back(32'hCAFE_F00D);
        access(1'b0, 32'h0000_EE44, '0, 0, "merged_word");
        exp_load.push_back(32'hEE40_0002);
        access(1'b0, 32'h0000_EE48, '0, 0, "filled_word");

        // 5: reset three cycles into WRITEBACK, then a stray ack
        mem_lat = 50;
        exp_txn.push_back('{wr: 1'b1, addr: 32'h0000_66A0, data: pat(32'h3300_0000)});
        @(posedge clk_i); #1;
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h0000_88A0;
        n = 0;
        @(negedge clk_i);
        while (!(mem_enable_o && mem_write_o) && n < 20) begin
            n++;
            @(negedge clk_i);
        end
        check("wb_reached", {mem_enable_o, mem_write_o}, 2'b11);
        repeat (2) @(negedge clk_i);
        #1 rst_i = 1'b1; cpu_req_i = 1'b0;
        #1 check("rst_async_drop", {mem_enable_o, cpu_stall_o}, 2'b00);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 manual_ack = 1'b1;
        @(negedge clk_i);
        check("stray_ack_a", {sram_enable_o, sram_write_o, mem_enable_o, cpu_stall_o}, 4'b0000);
        @(posedge clk_i); #1 manual_ack = 1'b0;
        @(negedge clk_i);
        check("stray_ack_b", {sram_enable_o, sram_write_o, mem_enable_o, cpu_stall_o}, 4'b0000);
        check("set5_untouched", m_tag[5][0], {2'b11, 23'h000033});
        exp_load.push_back(32'h3300_0001);
        access(1'b0, 32'h0000_66A4, '0, 0, "post_reset_hit");

        // 6: ack pulse while idle with no request
        idle();
        #1 manual_ack = 1'b1;
        @(negedge clk_i);
        check("idle_ack_a", {sram_enable_o, sram_write_o, mem_enable_o, cpu_stall_o}, 4'b0000);
        @(posedge clk_i); #1 manual_ack = 1'b0;
        @(negedge clk_i);
        check("idle_ack_b", {sram_enable_o, sram_write_o, mem_enable_o, cpu_stall_o}, 4'b0000);
        exp_load.push_back(32'hDEAD_BEEF);
        access(1'b0, 32'h0015_7868, '0, 0, "idle_ack_hit");
        idle();

        repeat (2) @(negedge clk_i);
        check("load_queue_empty", exp_load.size(), 0);
        check("txn_queue_empty", exp_txn.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Sequencing controller for the 2-way set-associative L1 data cache (16 sets, 256-bit lines, 25-bit tag entries of {valid, dirty, tag[22:0]}).
- Sits between the pipeline MEM stage and the dcache SRAM array, and owns the backing-memory handshake.
- Handles hits in the cycle the request arrives.
- Handles misses with write-back of a dirty victim, line fill and replay, stalling the CPU throughout.

Parameters:
- ADDR_W, 32, CPU and memory byte address width
- TAG_W, 23, address tag bits [31:9]
- IDX_W, 4, set index bits [8:5]
- OFS_W, 5, byte offset bits [4:0] (32-byte line)
- WORD_W, 32, CPU data width
- LINE_W, 256, cache line width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cpu_req_i  in  1  CPU access request (MemRead|MemWrite)
- cpu_write_i  in  1  1=store, 0=load
- cpu_addr_i  in  32  byte address
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  pipeline stall
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  {valid, dirty, tag} to SRAM
- sram_data_o  out  256  line to SRAM
- sram_enable_o  out  1  SRAM access enable
- sram_write_o  out  1  SRAM write
- sram_tag_i  in  25  hit-way tag; on miss, the LRU victim tag
- sram_data_i  in  256  hit-way line; on miss, the LRU victim line
- sram_hit_i  in  1  hit indication (combinational)
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1=write-back, 0=fill read
- mem_addr_o  out  32  line address, offset forced to 0
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  fill line
- mem_ack_i  in  1  single-cycle completion pulse

Behaviour:

Reset (asynchronous):
- State goes to IDLE immediately.
- All outputs are 0, including cpu_stall_o=0 and mem_enable_o=0.
- The fill buffer is cleared.
- A reset during WRITEBACK or FILL abandons the transfer. Any later mem_ack_i is ignored.

Address split:
- tag = addr[31:9], idx = addr[8:5], word = addr[4:2].
- Word k is line[32k+31:32k].

State IDLE:
- sram_enable_o = cpu_req_i and sram_addr_o = idx.
- Read hit: cpu_data_o = selected word; stall = 0; no state change; zero-latency, combinational.
- Write hit: in the same cycle, sram_write_o = 1, sram_data_o = sram_data_i with the selected word replaced by cpu_data_i, and sram_tag_o = {1,1,tag}. Stall = 0.
- Miss: cpu_stall_o = 1 combinationally. Victim tag and data are latched. Next state is MISS.
- cpu_req_i = 0: all SRAM and memory strobes are 0.

State MISS:
- Exactly one cycle.
- If the victim has valid&dirty (bits 24 and 23 both 1), next state is WRITEBACK.
- Otherwise next state is FILL.

State WRITEBACK:
- mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, idx, 5'b0}, mem_data_o = latched victim line.
- All four are held stable until mem_ack_i. Then next state is FILL.

State FILL:
- mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {tag, idx, 5'b0}.
- On mem_ack_i: mem_data_i is captured into the fill buffer, and next state is REFILL.

State REFILL:
- sram_enable_o = 1, sram_write_o = 1, sram_tag_o = {1,0,tag}, sram_data_o = fill buffer.
- The SRAM allocates the line into the LRU way. Next state is IDLE.

Replay:
- The request is re-evaluated in IDLE and is now a hit.
- A store merges its word at that point and sets dirty.
- Miss penalty = 3 + memory latency, plus the write-back latency if the victim is dirty.

CPU contract:
- cpu_req_i, cpu_write_i, cpu_addr_i and cpu_data_i are held stable while cpu_stall_o = 1.
- If cpu_req_i drops mid-miss, the controller still completes the fill and then idles.

Boundary conditions:
- mem_ack_i outside WRITEBACK/FILL is ignored.
- mem_enable_o is never asserted in IDLE, MISS or REFILL.
- cpu_stall_o = 1 in MISS, WRITEBACK, FILL and REFILL.
- An invalid victim (valid = 0) is never written back, regardless of the dirty bit.
- Back-to-back hits sustain 1 access per cycle.

Decomposition:
- Package dcache_pkg:
  - width constants: ADDR_W, TAG_W, IDX_W, OFS_W, WORD_W, LINE_W
  - tag-entry bit positions: VALID_BIT = 24, DIRTY_BIT = 23
  - state enum: IDLE, MISS, WRITEBACK, FILL, REFILL
  - address field-extraction functions
- Sub-module dcache_word_mux: combinational read-word select and write-word merge on a 256-bit line, indexed by the 3-bit word.

Test Plan:
1. Preload set 3 with tag 0x00ABC, clean; load addr {0x00ABC, 4'd3, 5'h08} -> cpu_data_o = word 2 in the same cycle; stall stays 0; mem_enable_o = 0.
2. Store 0xDEADBEEF to the same address -> sram_write_o = 1 for one cycle with sram_tag_o = {1,1,0x00ABC}; a subsequent load returns 0xDEADBEEF.
3. Clean load miss to 0x0000_1240 with the memory acking after 10 cycles -> MISS→FILL; mem_addr_o = 0x0000_1240; mem_write_o = 0; stall for 13 cycles; after the replay, cpu_data_o = word 2 of mem_data_i.
4. Miss whose victim tag is {1,1,0x000055} in set 2 -> write-back issued to 0x0000AA40 with the victim line, then fill read of the requested line; only one mem_enable_o transaction at a time.
5. Assert rst_i three cycles into WRITEBACK -> mem_enable_o and cpu_stall_o drop asynchronously; state is IDLE; a mem_ack_i pulse two cycles later causes no SRAM write.
6. Pulse mem_ack_i while in IDLE with no request -> no state change, all strobes remain 0.
